// File: rtl/chunked_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder_pkg
// Description : Shared types and helpers for the chunked multi-cycle adder.
//               Provides the controller state encoding, the chunk-count
//               helper and the WIDTH/CHUNK legality check used at
//               elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-wide slices in a WIDTH-wide operand.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal configuration: both positive and WIDTH an exact multiple of CHUNK.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (width > 0) && (chunk > 0) && ((width % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunked_adder_chunk.sv
`default_nettype none
// ============================================================================
// Module      : adder_chunk
// Description : Combinational CHUNK-bit ripple-carry adder built from full
//               adders. Reused every RUN cycle of chunked_adder.
// Ports       : i_a    [CHUNK-1:0]  operand A slice
//               i_b    [CHUNK-1:0]  operand B slice (already inverted for sub)
//               i_cin               carry into bit 0
//               o_sum  [CHUNK-1:0]  slice result
//               o_cout              carry out of bit CHUNK-1
// Revision    : 1.0 - initial release
// ============================================================================
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_carry[CHUNK];

endmodule
`default_nettype wire

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder
// Description : Multi-cycle adder/subtractor. Operands are latched on a
//               valid/ready handshake and summed CHUNK bits per clock with
//               the carry registered between chunks. The result is held in
//               DONE until the consumer accepts it.
//               Optional feature macro: CHUNKED_ADDER_OVF_EN (signed overflow
//               output; when undefined, ovf is tied low).
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready      operand handshake
//               a, b [WIDTH-1:0], cin, sub   operands and mode
//               out_valid / out_ready    result handshake
//               sum [WIDTH-1:0], cout, ovf   registered result
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] C_LAST = KW'(NCHUNK - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KW-1:0]    r_k;
  logic             r_c;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [CHUNK-1:0] w_chunk_a;
  logic [CHUNK-1:0] w_chunk_b;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_chunk_cout;
  logic             w_last;
  logic             w_accept;

  // Single adder slice, operands selected by the running chunk index.
  assign w_chunk_a = r_a[r_k*CHUNK +: CHUNK];
  assign w_chunk_b = r_b[r_k*CHUNK +: CHUNK];

  adder_chunk #(
    .CHUNK (CHUNK)
  ) u_adder_chunk (
    .i_a    (w_chunk_a),
    .i_b    (w_chunk_b),
    .i_cin  (r_c),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout)
  );

  assign w_last   = (r_k == C_LAST);
  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs decode only the state register, so neither in_* nor
  // out_ready reaches an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_c    <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      if (w_accept) begin
        // Subtraction is A + ~B + ~cin; invert once at capture.
        r_a <= a;
        r_b <= sub ? ~b : b;
        r_c <= sub ? ~cin : cin;
        r_k <= '0;
      end else if (r_state == RUN) begin
        r_sum[r_k*CHUNK +: CHUNK] <= w_chunk_sum;
        r_c                       <= w_chunk_cout;
        r_k                       <= w_last ? '0 : r_k + KW'(1);
        if (w_last) r_cout <= w_chunk_cout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef CHUNKED_ADDER_OVF_EN
  logic r_ovf;

  // The top chunk's MSB is the result sign bit, available in the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_adder
// Description : Directed self-checking bench for chunked_adder. Drives a
//               32/8 instance and an 8/8 instance with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_adder;

`ifdef CHUNKED_ADDER_OVF_EN
  localparam logic C_OVF_ON = 1'b1;
`else
  localparam logic C_OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // 32-bit / 8-bit-chunk instance
  logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32;
  logic        cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  // 8-bit single-chunk instance
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8;
  logic        cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int n_checks = 0;
  int n_errors = 0;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .a         (a32),
    .b         (b32),
    .cin       (cin32),
    .sub       (sub32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .sum       (sum32),
    .cout      (cout32),
    .ovf       (ovf32)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .sub       (sub8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done32(output int n);
    n = 0;
    while (!out_valid32 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack32();
    @(negedge clk);
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check("ack_out_valid_low", {31'd0, out_valid32}, 32'd0);
  endtask

  // Issue one operation on the 32-bit instance and check result and latency.
  task automatic run32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tcin, input logic tsub, input logic [31:0] esum,
                       input logic ecout, input logic eovf_raw, input bit do_ack);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready32}, 32'd1);
    in_valid32 = 1'b1;
    a32 = ta; b32 = tb; cin32 = tcin; sub32 = tsub;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'hCAFE_F00D; cin32 = 1'b1; sub32 = ~tsub;
    wait_done32(n);
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_sum"},  sum32, esum);
    check({tag, "_cout"}, {31'd0, cout32}, {31'd0, ecout});
    check({tag, "_ovf"},  {31'd0, ovf32},  {31'd0, eovf_raw & C_OVF_ON});
    if (do_ack) ack32();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b0;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; out_ready8  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready32},  32'd1);
    check("rst_out_valid", {31'd0, out_valid32}, 32'd0);
    check("rst_sum",       sum32, 32'd0);
    check("rst_cout_ovf",  {30'd0, cout32, ovf32}, 32'd0);
    check("rst8_ready_valid", {30'd0, in_ready8, out_valid8}, 32'd2);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry ripples across all four chunks.
    run32("carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    // Positive overflow into the sign bit.
    run32("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    // Subtraction with borrow out (cout=0 means borrow).
    run32("sub_c0", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    run32("sub_c1", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
    // Add with carry-in.
    run32("add_cin", 32'h1234_5678, 32'h0000_0001, 1'b1, 1'b0, 32'h1234_567A, 1'b0, 1'b0, 1'b1);

    // Backpressure: 0x100 - 1 = 0xFF with no borrow, held for 5 cycles while
    // a new operation waits on in_valid.
    run32("bp", 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid32 = 1'b1;
      a32 = 32'hA000_0000; b32 = 32'hA000_0000; cin32 = 1'b0; sub32 = 1'b0;
      @(posedge clk); #1;
      check("bp_in_ready_low", {31'd0, in_ready32}, 32'd0);
      check("bp_sum_hold", {sum32[30:0], cout32}, {31'h0000_00FF, 1'b1});
      check("bp_out_valid", {31'd0, out_valid32}, 32'd1);
    end
    @(negedge clk);
    out_ready32 = 1'b1;
    @(posedge clk); #1;
    out_ready32 = 1'b0;
    check("b2b_idle_ready", {30'd0, in_ready32, out_valid32}, 32'd2);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("b2b_accepted", {31'd0, in_ready32}, 32'd0);
    wait_done32(n);
    check("b2b_latency", n, 32'd4);
    check("b2b_sum", sum32, 32'h4000_0000);
    check("b2b_cout_ovf", {30'd0, cout32, ovf32}, {30'd0, 1'b1, C_OVF_ON});
    ack32();

    // Reset during RUN after chunk 1 has been written.
    @(negedge clk);
    in_valid32 = 1'b1;
    a32 = 32'h1234_5678; b32 = 32'h1111_1111; cin32 = 1'b0; sub32 = 1'b0;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_partial", {16'd0, sum32[15:0]}, 32'h0000_6789);
    rst_n = 1'b0;
    #1;
    check("midrst_ready_valid", {30'd0, in_ready32, out_valid32}, 32'd2);
    check("midrst_sum", sum32, 32'd0);
    check("midrst_cout_ovf", {30'd0, cout32, ovf32}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run32("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b1);

    // Single-chunk instance: latency 1.
    @(negedge clk);
    check("w8_in_ready", {31'd0, in_ready8}, 32'd1);
    in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", n, 32'd1);
    check("w8_sum", {24'd0, sum8}, 32'h0000_0000);
    check("w8_cout_ovf", {30'd0, cout8, ovf8}, {30'd0, 1'b1, C_OVF_ON});
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("w8_ack", {30'd0, in_ready8, out_valid8}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
